// File: rtl/icache_fill_unit.sv
// Instruction-cache line fill: fetches one 128-bit line as two 64-bit beats and returns it.
// Optional watchdog on the beat phase is enabled by defining ICACHE_FILL_TIMEOUT_EN.
module icache_fill_unit #(
    parameter int PADDR_W     = 26,
    parameter int N_WAY       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    input  logic [$clog2(N_WAY)-1:0] req_way_i,
    input  logic [PADDR_W-1:0]       req_paddr_i,
    input  logic                     req_kill_i,
    output logic                     req_ready_o,
    output logic                     resp_valid_o,
    output logic                     resp_ack_o,
    output logic                     resp_err_o,
    output logic [127:0]             resp_data_o,
    output logic [$clog2(N_WAY)-1:0] resp_way_o,
    output logic [1:0]               resp_beat_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [PADDR_W-1:0]       mem_req_addr_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [63:0]              mem_rsp_data_i,
    input  logic                     mem_rsp_last_i,
    input  logic                     mem_rsp_err_i,
    output logic                     busy_o
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end
    if (N_WAY < 2) begin : g_bad_ways
        $error("N_WAY must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        WAIT_BEATS,
        RESP,
        DRAIN
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [$clog2(N_WAY)-1:0]   way_q;
    logic [PADDR_W-1:0]         addr_q;
    logic [127:0]               data_q;
    logic [1:0]                 beat_q;
    logic                       err_q;
    logic                       ack_q;
    logic                       beat_done;
    logic                       beat_bad;
    logic                       wd_expired;

    // A beat completes the line when one beat has already been counted.
    assign beat_done = mem_rsp_valid_i && (beat_q == 2'd1);
    // Beat 0 must not carry last, beat 1 must carry it.
    assign beat_bad  = mem_rsp_err_i || (mem_rsp_last_i != beat_q[0]);

`ifdef ICACHE_FILL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_active;

    assign wd_active  = (state_q == WAIT_BEATS) || (state_q == DRAIN);
    assign wd_expired = wd_active && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !wd_active || (state_d != state_q)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = MEM_REQ;
            end
            MEM_REQ: begin
                if (mem_req_ready_i)  state_d = req_kill_i ? DRAIN : WAIT_BEATS;
                else if (req_kill_i)  state_d = IDLE;
            end
            WAIT_BEATS: begin
                // A kill that coincides with the final beat has nothing left to drain.
                if (req_kill_i)      state_d = beat_done ? IDLE : DRAIN;
                else if (beat_done)  state_d = RESP;
                else if (wd_expired) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (beat_done || wd_expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o     = (state_q == IDLE);
        busy_o          = (state_q != IDLE);
        mem_req_valid_o = (state_q == MEM_REQ);
        resp_valid_o    = (state_q == RESP);
        resp_err_o      = (state_q == RESP) && err_q;
        resp_ack_o      = ack_q;
        mem_req_addr_o  = addr_q;
        resp_data_o     = data_q;
        resp_way_o      = way_q;
        resp_beat_o     = beat_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            way_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ack_q <= (state_q == IDLE) && req_valid_i;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        way_q  <= req_way_i;
                        addr_q <= req_paddr_i & ~PADDR_W'(15);
                        data_q <= '0;
                        beat_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                WAIT_BEATS: begin
                    if (mem_rsp_valid_i) begin
                        if (beat_q[0]) data_q[127:64] <= mem_rsp_data_i;
                        else           data_q[63:0]   <= mem_rsp_data_i;
                        beat_q <= beat_q + 2'd1;
                        if (beat_bad) err_q <= 1'b1;
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_rsp_valid_i) beat_q <= beat_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Scoreboard bench for icache_fill_unit: randomized fills, kills and resets against a line-level model.
module tb_icache_fill_unit;
    localparam int PADDR_W     = 26;
    localparam int N_WAY       = 4;
    localparam int TIMEOUT_CYC = 8;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               req_valid_i = 1'b0;
    logic [1:0]         req_way_i = '0;
    logic [PADDR_W-1:0] req_paddr_i = '0;
    logic               req_kill_i = 1'b0;
    logic               req_ready_o;
    logic               resp_valid_o;
    logic               resp_ack_o;
    logic               resp_err_o;
    logic [127:0]       resp_data_o;
    logic [1:0]         resp_way_o;
    logic [1:0]         resp_beat_o;
    logic               mem_req_valid_o;
    logic               mem_req_ready_i = 1'b0;
    logic [PADDR_W-1:0] mem_req_addr_o;
    logic               mem_rsp_valid_i = 1'b0;
    logic [63:0]        mem_rsp_data_i = '0;
    logic               mem_rsp_last_i = 1'b0;
    logic               mem_rsp_err_i = 1'b0;
    logic               busy_o;

    icache_fill_unit #(
        .PADDR_W(PADDR_W),
        .N_WAY(N_WAY),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_way_i(req_way_i),
        .req_paddr_i(req_paddr_i),
        .req_kill_i(req_kill_i),
        .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o),
        .resp_ack_o(resp_ack_o),
        .resp_err_o(resp_err_o),
        .resp_data_o(resp_data_o),
        .resp_way_o(resp_way_o),
        .resp_beat_o(resp_beat_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i),
        .mem_rsp_last_i(mem_rsp_last_i),
        .mem_rsp_err_i(mem_rsp_err_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] data;
        logic         chk_data;
        logic [1:0]   way;
        logic         err;
        logic [1:0]   beat;
    } resp_t;

    resp_t              exp_resp_q[$];
    logic [PADDR_W-1:0] exp_addr_q[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: responses and memory handshakes are matched against the queued expectations.
    logic               prev_mvalid = 1'b0;
    logic               prev_mready = 1'b0;
    logic               prev_ack    = 1'b0;
    logic [PADDR_W-1:0] prev_maddr  = '0;
    resp_t              mon_r;
    logic [PADDR_W-1:0] mon_a;

    always @(negedge clk_i) begin
        if (resp_valid_o) begin
            if (exp_resp_q.size() == 0) begin
                check("unexpected_resp_valid", 1, 0);
            end else begin
                mon_r = exp_resp_q.pop_front();
                if (mon_r.chk_data) check("resp_data", resp_data_o, mon_r.data);
                check("resp_way", resp_way_o, mon_r.way);
                check("resp_beat", resp_beat_o, mon_r.beat);
                check("resp_err", resp_err_o, mon_r.err);
            end
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_mem_handshake", 1, 0);
            end else begin
                mon_a = exp_addr_q.pop_front();
                check("mem_req_addr", mem_req_addr_o, mon_a);
            end
        end
        if (mem_req_valid_o && prev_mvalid && !prev_mready)
            check("mem_addr_stable", mem_req_addr_o, prev_maddr);
        if (resp_ack_o)
            check("ack_single_cycle", prev_ack, 0);
        prev_mvalid = mem_req_valid_o;
        prev_mready = mem_req_ready_i;
        prev_maddr  = mem_req_addr_o;
        prev_ack    = resp_ack_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready_o, 1);
        check({tag, "_ctrl_zero"},
              {resp_valid_o, resp_ack_o, resp_err_o, mem_req_valid_o, busy_o}, 0);
        check({tag, "_data"}, resp_data_o, 0);
        check({tag, "_way_beat"}, {resp_way_o, resp_beat_o}, 0);
        check({tag, "_addr"}, mem_req_addr_o, 0);
    endtask

    // Idle cycles inside a fill, with request/beat noise the unit must ignore.
    task automatic noise_cycles(input int n, input logic stray_beats);
        for (int i = 0; i < n; i++) begin
            req_valid_i     = ($urandom_range(0, 1) == 1);
            req_paddr_i     = PADDR_W'($urandom);
            mem_rsp_valid_i = stray_beats && ($urandom_range(0, 1) == 1);
            mem_rsp_data_i  = {$urandom, $urandom};
            tick();
        end
        req_valid_i     = 1'b0;
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input logic err,
                             input logic kill);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        mem_rsp_last_i  = last;
        mem_rsp_err_i   = err;
        req_kill_i      = kill;
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_last_i  = 1'b0;
        mem_rsp_err_i   = 1'b0;
        req_kill_i      = 1'b0;
        mem_rsp_data_i  = {$urandom, $urandom};
    endtask

    task automatic accept(input logic [PADDR_W-1:0] paddr, input logic [1:0] way);
        int n = 0;
        while (!req_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_paddr_i = paddr;
        req_way_i   = way;
        tick();
        req_valid_i = 1'b0;
        req_paddr_i = PADDR_W'($urandom);
        req_way_i   = 2'($urandom);
        check("ack_next_cycle", resp_ack_o, 1);
    endtask

    // kill_mode: 0 none, 1 kill while waiting for ready, 2 kill after beat 0,
    // 3 kill together with beat 0, 4 kill together with the ready handshake.
    task automatic do_fill(input logic [PADDR_W-1:0] paddr, input logic [1:0] way,
                           input int delay, input int kill_mode,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic e0, input logic e1, input logic l0, input logic l1);
        resp_t r;
        if (kill_mode != 1) exp_addr_q.push_back(paddr & ~PADDR_W'(15));
        if (kill_mode == 0) begin
            r.data     = {b1, b0};
            r.chk_data = 1'b1;
            r.way      = way;
            r.err      = e0 | e1 | l0 | !l1;
            r.beat     = 2'd2;
            exp_resp_q.push_back(r);
        end
        accept(paddr, way);
        mem_req_ready_i = 1'b0;
        noise_cycles(delay, 1'b1);
        if (kill_mode == 1) begin
            req_kill_i = 1'b1;
            tick();
            req_kill_i = 1'b0;
            check("kill_in_mem_req_idle", {busy_o, req_ready_o}, 2'b01);
            return;
        end
        mem_req_ready_i = 1'b1;
        req_kill_i      = (kill_mode == 4);
        tick();
        mem_req_ready_i = 1'b0;
        req_kill_i      = 1'b0;
        noise_cycles($urandom_range(0, 2), 1'b0);
        send_beat(b0, l0, e0, kill_mode == 3);
        if (kill_mode == 2) begin
            req_kill_i = 1'b1;
            tick();
            req_kill_i = 1'b0;
        end
        noise_cycles($urandom_range(0, 2), 1'b0);
        send_beat(b1, l1, e1, 1'b0);
        if (kill_mode != 0) begin
            check("drain_busy_drop", busy_o, 0);
        end else begin
            check("resp_after_last_beat", resp_valid_o, 1);
            tick();
            check("resp_one_cycle", resp_valid_o, 0);
            check("resp_data_hold", resp_data_o, {b1, b0});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within bound");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        logic [PADDR_W-1:0] pa;
        int                 m;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();

        // Basic line fill with immediate ready.
        do_fill(26'h0123456, 2'd2, 0, 0, 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD,
                1'b0, 1'b0, 1'b0, 1'b1);
        check("line_addr_basic", mem_req_addr_o, 26'h0123450);
        // Ready held off five cycles.
        do_fill(26'h3FFFFFF, 2'd1, 5, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b0, 1'b0, 1'b0, 1'b1);
        // Error on beat 1, then a clean fill.
        do_fill(26'h0000010, 2'd3, 1, 0, 64'h5, 64'h6, 1'b0, 1'b1, 1'b0, 1'b1);
        do_fill(26'h0000020, 2'd0, 0, 0, 64'h7, 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
        // Protocol errors on the last flag.
        do_fill(26'h0000030, 2'd1, 0, 0, 64'h9, 64'hA, 1'b0, 1'b0, 1'b1, 1'b1);
        do_fill(26'h0000040, 2'd2, 0, 0, 64'hB, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        // Kill after beat 0, then a back-to-back normal fill.
        do_fill(26'h0000050, 2'd3, 0, 2, 64'hD, 64'hE, 1'b0, 1'b0, 1'b0, 1'b1);
        do_fill(26'h0000060, 2'd1, 0, 0, 64'hF, 64'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        do_fill(26'h0000070, 2'd0, 3, 1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_fill(26'h0000080, 2'd2, 0, 3, 64'h11, 64'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        do_fill(26'h0000090, 2'd1, 2, 4, 64'h13, 64'h14, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a fill; the late beat must be ignored.
        exp_addr_q.push_back(26'h00ABCD0);
        accept(26'h00ABCDE, 2'd3);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        send_beat(64'h1234, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        send_beat(64'h5678, 1'b1, 1'b0, 1'b0);
        check_reset_outputs("midfill_reset");

        for (int i = 0; i < 40; i++) begin
            pa = PADDR_W'($urandom);
            m  = $urandom_range(0, 9);
            do_fill(pa, 2'($urandom), $urandom_range(0, 5), (m < 6) ? 0 : m - 5,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
        end

`ifdef ICACHE_FILL_TIMEOUT_EN
        begin
            resp_t r;
            r.data     = '0;
            r.chk_data = 1'b0;
            r.way      = 2'd2;
            r.err      = 1'b1;
            r.beat     = 2'd0;
            exp_addr_q.push_back(26'h0200000);
            exp_resp_q.push_back(r);
            accept(26'h0200000, 2'd2);
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0;
            repeat (TIMEOUT_CYC - 1) tick();
            check("watchdog_not_early", resp_valid_o, 0);
            tick();
            check("watchdog_fires", resp_valid_o, 1);
            tick();
        end
`endif

        repeat (4) tick();
        check("resp_queue_drained", exp_resp_q.size(), 0);
        check("mem_queue_drained", exp_addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
